// File: rtl/pio_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced PIO peripheral.
// The host side drives address/strobes/data; the peripheral returns registered read data.
interface pio_debounce_irq_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_debounce_irq.sv
// Parallel I/O peripheral: synchronised, debounced, edge-captured inputs with masked level IRQ,
// plus an output register with direct, set and clear writes.
module pio_debounce_irq #(
  parameter int               WIDTH     = 18,
  parameter int               DB_CYCLES = 50000,
  parameter int               EDGE_MODE = 0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  pio_debounce_irq_if.slave   avs,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic                irq
);

  localparam int               CNT_W   = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_OUTPUT   = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLR   = 3'd5;

  logic [WIDTH-1:0] sync_meta, sync;
  logic [WIDTH-1:0] stable, stable_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] cap, mask;
  logic [WIDTH-1:0] edge_hit, cap_clr, wr_data;
  logic [31:0]      rd_word;

  // Upper write-data bits beyond WIDTH are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  assign wr_data = avs.avs_writedata[WIDTH-1:0];
  assign cap_clr = (avs.avs_write && avs.avs_address == REG_EDGE_CAP) ? wr_data : '0;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) stable_next[i] = sync[i];
        else                   cnt_next[i]    = cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    case (EDGE_MODE)
      0:       edge_hit = stable_next & ~stable;
      1:       edge_hit = ~stable_next & stable;
      default: edge_hit = stable_next ^ stable;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (avs.avs_address)
      REG_DATA:     rd_word[WIDTH-1:0] = stable;
      REG_OUTPUT:   rd_word[WIDTH-1:0] = gpio_out;
      REG_IRQ_MASK: rd_word[WIDTH-1:0] = mask;
      REG_EDGE_CAP: rd_word[WIDTH-1:0] = cap;
      default:      rd_word = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_meta <= '0;
      sync      <= '0;
      stable    <= '0;
      // NOTE: the counter array is reset so a reset mid-debounce discards any partial count.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync_meta <= gpio_in;
      sync      <= sync_meta;
      stable    <= stable_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // A fresh edge wins over a write-1-clear of the same bit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cap               <= '0;
      mask              <= '0;
      gpio_out          <= OUT_RESET;
      avs.avs_readdata  <= '0;
    end else begin
      cap <= (cap & ~cap_clr) | edge_hit;
      if (avs.avs_write) begin
        case (avs.avs_address)
          REG_DATA:     gpio_out <= wr_data;
          REG_IRQ_MASK: mask     <= wr_data;
          REG_OUTSET:   gpio_out <= gpio_out | wr_data;
          REG_OUTCLR:   gpio_out <= gpio_out & ~wr_data;
          default:      ;
        endcase
      end
      if (avs.avs_read) avs.avs_readdata <= rd_word;
    end
  end

  assign irq = |(cap & mask);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Self-checking bench for pio_debounce_irq: cycle model of the register map plus directed
// scenarios covering reset, debounce, capture/IRQ, output ops, width masking and mid-count reset.
module tb_pio_debounce_irq;
  localparam int          WIDTH   = 18;
  localparam int          DB      = 4;
  localparam int          MODE    = 2;
  localparam logic [17:0] OUT_RST = 18'h0000F;
  localparam logic [31:0] WMASK   = 32'h0003FFFF;

  logic             clk_clk     = 1'b0;
  logic             reset_reset = 1'b1;
  logic [WIDTH-1:0] gpio_in     = '0;
  logic [WIDTH-1:0] gpio_out;
  logic             irq;

  int checks = 0;
  int errors = 0;

  pio_debounce_irq_if avs ();

  pio_debounce_irq #(
    .WIDTH(WIDTH), .DB_CYCLES(DB), .EDGE_MODE(MODE), .OUT_RESET(OUT_RST)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .avs(avs),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: input seen two edges late; a channel flips once its delayed input has disagreed
  // with the accepted value for DB consecutive edges.
  logic [31:0] m_dly0, m_dly1, m_st, m_cap, m_mask, m_out, m_rd;
  int          m_run [WIDTH];

  always @(posedge clk_clk or posedge reset_reset) begin : model
    logic [31:0] d, nst, chg, wd;
    if (reset_reset) begin
      m_dly0 = 0; m_dly1 = 0; m_st = 0; m_cap = 0; m_mask = 0;
      m_out  = 32'(OUT_RST); m_rd = 0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      d   = m_dly1;
      nst = m_st;
      for (int i = 0; i < WIDTH; i++) begin
        if (d[i] != m_st[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            nst[i]   = d[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      chg = (MODE == 0) ? (nst & ~m_st) : (MODE == 1) ? (~nst & m_st) : (nst ^ m_st);
      if (avs.avs_read) begin
        case (avs.avs_address)
          3'd0:    m_rd = m_st;
          3'd1:    m_rd = m_out;
          3'd2:    m_rd = m_mask;
          3'd3:    m_rd = m_cap;
          default: m_rd = 0;
        endcase
      end
      wd    = avs.avs_writedata & WMASK;
      m_cap = (m_cap & ~((avs.avs_write && avs.avs_address == 3'd3) ? wd : 32'h0)) | chg;
      if (avs.avs_write) begin
        case (avs.avs_address)
          3'd0:    m_out = wd;
          3'd2:    m_mask = wd;
          3'd4:    m_out = m_out | wd;
          3'd5:    m_out = m_out & ~wd;
          default: ;
        endcase
      end
      m_dly1 = m_dly0;
      m_dly0 = 32'(gpio_in);
      m_st   = nst;
    end
  end

  always @(negedge clk_clk) begin
    check("model_gpio_out", 32'(gpio_out), m_out);
    check("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    check("model_readdata", avs.avs_readdata, m_rd);
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs.avs_address   = a;
    avs.avs_writedata = d;
    avs.avs_write     = 1'b1;
    @(negedge clk_clk);
    avs.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs.avs_address = a;
    avs.avs_read    = 1'b1;
    @(negedge clk_clk);
    avs.avs_read    = 1'b0;
    d = avs.avs_readdata;
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [31:0] rst_exp [6];
    rst_exp = '{32'h0, 32'h0000000F, 32'h0, 32'h0, 32'h0, 32'h0};
    avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0; avs.avs_writedata = '0;

    // Reset values
    repeat (2) @(negedge clk_clk);
    check("rst_gpio_out", 32'(gpio_out), 32'h0000000F);
    check("rst_irq", 32'(irq), 32'h0);
    reset_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_read(3'(i), r);
      check("rst_reg_read", r, rst_exp[i]);
      check("rst_irq_hold", 32'(irq), 32'h0);
    end

    // Glitch of 3 clocks is rejected
    bus_write(3'd2, 32'h8);
    @(negedge clk_clk) gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk_clk);
    gpio_in[3] = 1'b0;
    repeat (8) @(negedge clk_clk);
    bus_read(3'd0, r); check("glitch_data", r, 32'h0);
    bus_read(3'd3, r); check("glitch_cap", r, 32'h0);

    // Held input accepted exactly 6 edges after the change
    @(negedge clk_clk) gpio_in[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_clk);
      check("db_irq_edge", 32'(irq), (k == 6) ? 32'h1 : 32'h0);
    end
    bus_read(3'd0, r); check("db_data", r, 32'h8);
    bus_read(3'd3, r); check("db_cap", r, 32'h8);

    // Clear removes irq next cycle; falling edge captured in both-edge mode
    bus_write(3'd3, 32'h8);
    check("irq_after_clear", 32'(irq), 32'h0);
    @(negedge clk_clk) gpio_in[3] = 1'b0;
    repeat (5) @(negedge clk_clk);
    check("fall_irq_early", 32'(irq), 32'h0);
    @(negedge clk_clk);
    check("fall_irq", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h8);

    // New edge lands on the same edge as a clear write: set wins
    @(negedge clk_clk) gpio_in[3] = 1'b1;
    repeat (4) @(negedge clk_clk);
    bus_write(3'd3, 32'h8);
    check("collide_irq", 32'(irq), 32'h1);
    bus_read(3'd3, r); check("collide_cap", r, 32'h8);
    bus_write(3'd3, 32'h8);

    // Output ops with back-to-back OUTSET/OUTCLR
    bus_write(3'd0, 32'h0F0);
    @(negedge clk_clk);
    avs.avs_address = 3'd4; avs.avs_writedata = 32'h003; avs.avs_write = 1'b1;
    @(negedge clk_clk);
    avs.avs_address = 3'd5; avs.avs_writedata = 32'h010;
    @(negedge clk_clk);
    avs.avs_write = 1'b0;
    check("out_ops_gpio", 32'(gpio_out), 32'h0E3);
    bus_read(3'd1, r); check("out_ops_read", r, 32'h0E3);
    bus_read(3'd4, r); check("outset_read", r, 32'h0);
    bus_read(3'd5, r); check("outclr_read", r, 32'h0);

    // Width masking and unused addresses
    bus_write(3'd2, 32'hFFFFFFFF);
    bus_read(3'd2, r); check("mask_width", r, 32'h0003FFFF);
    bus_read(3'd6, r); check("reg6_read", r, 32'h0);
    bus_read(3'd7, r); check("reg7_read", r, 32'h0);
    bus_write(3'd7, 32'hFFFFFFFF);
    check("reg7_write_ignored", 32'(gpio_out), 32'h0E3);

    // Simultaneous read/write returns pre-write value; readdata holds while idle
    @(negedge clk_clk);
    avs.avs_address = 3'd2; avs.avs_writedata = 32'h5;
    avs.avs_read = 1'b1; avs.avs_write = 1'b1;
    @(negedge clk_clk);
    avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    check("rw_same_addr", avs.avs_readdata, 32'h0003FFFF);
    bus_read(3'd2, r); check("rw_new_mask", r, 32'h5);
    repeat (3) @(negedge clk_clk);
    check("readdata_hold", avs.avs_readdata, 32'h5);

    // Reset at cnt=2 on channel 0; both held channels capture at edge 6 after release
    @(negedge clk_clk) gpio_in = 18'h9;
    repeat (4) @(negedge clk_clk);
    #2 reset_reset = 1'b1;
    #1;
    check("midrst_gpio_out", 32'(gpio_out), 32'h0000000F);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_readdata", avs.avs_readdata, 32'h0);
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (5) @(negedge clk_clk);
    avs.avs_address = 3'd3; avs.avs_read = 1'b1;
    @(negedge clk_clk);
    check("midrst_cap_pre6", avs.avs_readdata, 32'h0);
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
    check("midrst_cap_edge6", avs.avs_readdata, 32'h9);

    repeat (2) @(negedge clk_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
